full_adder_core: RTL and testbench

Registered, width-parameterized binary adder built from a chain of 1-bit full-adder cells. It computes S = A + B + C_I and carry-out C_O, registering both one clock after the inputs are sampled. It is the arithmetic leaf of the ALU datapath. With the default WIDTH = 1 it is the classic single-bit full adder with registered outputs.

---
 rtl/full_adder_pkg.sv | 11 +
 rtl/full_adder_cell.sv | 13 +
 rtl/full_adder_core.sv | 64 ++++++
 tb/tb_full_adder_core.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared constants and the 1-bit full-adder reference function
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;

  // Returns {cout, s} for one full-adder bit.
  function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - purely combinational 1-bit full-adder cell
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder_core.sv
// rtl/full_adder_core.sv - registered ripple-carry adder of WIDTH full-adder cells
// Optional signed-overflow output ovf is compiled in with FULL_ADDER_OVF_EN.
module full_adder_core
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] S,
  output logic             C_O,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_I,
  input  logic             in_valid,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = C_I;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Result registers hold their value while in_valid is low; out_valid is a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      S         <= '0;
      C_O       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S   <= sum;
        C_O <= carry[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Two's-complement overflow: carry into the MSB cell differs from its carry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_core.sv
// tb/tb_full_adder_core.sv - scoreboard bench for full_adder_core at WIDTH 1 and WIDTH 8
// ovf is checked only when FULL_ADDER_OVF_EN is defined.
module tb_full_adder_core;
  import full_adder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, v1 = 1'b0;
  logic       s1, co1, ov1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       c8 = 1'b0, v8 = 1'b0;
  logic [7:0] s8;
  logic       co8, ov8;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf1, ovf8;
`endif

  int checks   = 0;
  int failures = 0;

  logic [2:0] q1[$];
  logic [9:0] q8[$];
  logic [2:0] h1 = '0;
  logic [9:0] h8 = '0;

  always #5 clk = ~clk;

  full_adder_core #(.WIDTH(1)) d1 (
    .clk(clk), .rst(rst), .S(s1), .C_O(co1), .A(a1), .B(b1), .C_I(c1),
    .in_valid(v1), .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  full_adder_core #(.WIDTH(8)) d8 (
    .clk(clk), .rst(rst), .S(s8), .C_O(co8), .A(a8), .B(b8), .C_I(c8),
    .in_valid(v8), .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  // Reference results as {ovf, cout, sum}, built from the package bit function.
  function automatic logic [2:0] ref1(input logic a, input logic b, input logic c);
    logic [1:0] r;
    r = fa_bit(a, b, c);
    return {c ^ r[1], r};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic       c;
    logic       cin_msb;
    logic [1:0] r;
    logic [7:0] s;
    c       = ci;
    cin_msb = 1'b0;
    s       = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) cin_msb = c;
      r    = fa_bit(a[i], b[i], c);
      s[i] = r[0];
      c    = r[1];
    end
    return {cin_msb ^ c, c, s};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive both DUTs, push expectations, then compare after the edge.
  task automatic step(input logic r, input logic iv1, input logic [2:0] abc,
                      input logic iv8, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic e1, e8;
    rst = r;
    v1 = iv1; a1 = abc[2]; b1 = abc[1]; c1 = abc[0];
    v8 = iv8; a8 = a; b8 = b; c8 = c;
    e1 = !r && iv1;
    e8 = !r && iv8;
    if (r) begin
      q1.delete();
      q8.delete();
    end else begin
      if (iv1) q1.push_back(ref1(abc[2], abc[1], abc[0]));
      if (iv8) q8.push_back(ref8(a, b, c));
    end
    @(posedge clk);
    #1;
    if (r) begin
      h1 = '0;
      h8 = '0;
    end
    if (e1) h1 = q1.pop_front();
    if (e8) h8 = q8.pop_front();
    chk("w1_out_valid", {15'd0, ov1}, {15'd0, e1});
    chk("w1_co_s", {14'd0, co1, s1}, {14'd0, h1[1:0]});
    chk("w8_out_valid", {15'd0, ov8}, {15'd0, e8});
    chk("w8_co_s", {7'd0, co8, s8}, {7'd0, h8[8:0]});
`ifdef FULL_ADDER_OVF_EN
    chk("w1_ovf", {15'd0, ovf1}, {15'd0, h1[2]});
    chk("w8_ovf", {15'd0, ovf8}, {15'd0, h8[9]});
`endif
  endtask

  initial begin
    logic [1:0] tbl [8];
    tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    step(1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 3'(i), 1'b0, 8'h00, 8'h00, 1'b0);
      chk("w1_table", {14'd0, co1, s1}, {14'd0, tbl[i]});
    end

    // Reset after a loaded result, then reset colliding with in_valid.
    step(1'b0, 1'b1, 3'b111, 1'b1, 8'hFF, 8'hFF, 1'b1);
    step(1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("rst_s8_zero", {8'd0, s8}, 16'd0);
    step(1'b1, 1'b1, 3'b111, 1'b1, 8'h12, 8'h34, 1'b1);
    chk("rst_priority_valid", {15'd0, ov8}, 16'd0);
    step(1'b0, 1'b1, 3'b011, 1'b1, 8'h01, 8'h02, 1'b0);
    chk("first_after_rst", {15'd0, ov8}, 16'd1);

    // Hold with changing operands.
    step(1'b0, 1'b1, 3'b100, 1'b1, 8'h01, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'(i + 5), 1'b0, 8'(i * 37 + 3), 8'(i * 91 + 7), 1'(i));
      chk("hold_s1", {14'd0, co1, s1}, 16'd1);
      chk("hold_s8", {7'd0, co8, s8}, 16'd1);
    end

    step(1'b0, 1'b0, 3'b000, 1'b1, 8'hFF, 8'h00, 1'b1);
    chk("wrap_ff_00_1", {7'd0, co8, s8}, {7'd0, 1'b1, 8'h00});
    step(1'b0, 1'b0, 3'b000, 1'b1, 8'hFF, 8'hFF, 1'b1);
    chk("wrap_ff_ff_1", {7'd0, co8, s8}, {7'd0, 1'b1, 8'hFF});

    step(1'b0, 1'b0, 3'b000, 1'b1, 8'h7F, 8'h01, 1'b0);
    chk("sum_7f_01", {7'd0, co8, s8}, {7'd0, 1'b0, 8'h80});
`ifdef FULL_ADDER_OVF_EN
    chk("ovf_7f_01", {15'd0, ovf8}, 16'd1);
`endif
    step(1'b0, 1'b0, 3'b000, 1'b1, 8'h80, 8'h80, 1'b0);
    chk("co_80_80", {15'd0, co8}, 16'd1);
`ifdef FULL_ADDER_OVF_EN
    chk("ovf_80_80", {15'd0, ovf8}, 16'd1);
`endif
    step(1'b0, 1'b0, 3'b000, 1'b1, 8'h10, 8'h20, 1'b0);
    chk("sum_10_20", {8'd0, s8}, 16'h0030);
`ifdef FULL_ADDER_OVF_EN
    chk("ovf_10_20", {15'd0, ovf8}, 16'd0);
`endif

    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, 3'($urandom_range(0, 7)),
           1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
